// File: rtl/column_rr_arbiter.sv
// column_rr_arbiter
//
// Column-level arbiter that sits below the row arbiter. While the row is
// enabled, it grants the active column requests one at a time in ascending
// index order, one pass per row. Each grant is held until the requester
// acknowledges it or withdraws its request. When the pass has no unserved
// requests left, grp_release_o pulses so the parent can advance.
//
// Optional feature macro: COL_ARB_TIMEOUT_EN. When it is defined, a grant
// that waits TIMEOUT cycles without completion is forced to complete, and
// timeout_o pulses. When it is undefined, the timeout_o port does not exist.
//
// Ports:
//   clk_i          clock; all logic runs on its rising edge
//   reset_i        synchronous, active-high reset
//   enable_i       row selected; arbitration runs only while this is high
//   req_i          per-column request, level sensitive
//   ack_i          acknowledge of the current grant
//   gnt_o          one-hot registered grant
//   yadd_o         binary index of the granted column, 0 when idle
//   gnt_valid_o    high exactly when gnt_o is nonzero
//   grp_release_o  one-cycle pulse at the end of a pass
//   timeout_o      one-cycle pulse on a forced completion (macro builds only)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no pass in progress; mask is all ones
// ARB     | pick the lowest requesting column above the last grant
// GRANT   | grant held until ack, withdrawal or timeout
// RELEASE | pass finished; grp_release_o is high for this one cycle

module column_rr_arbiter #(
   parameter int Lvl_COLS    = 4,
   parameter int Lvl_COL_ADD = 2,
   parameter int TIMEOUT     = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic [Lvl_COLS-1:0]    req_i,
   input  logic                   ack_i,
   output logic [Lvl_COLS-1:0]    gnt_o,
   output logic [Lvl_COL_ADD-1:0] yadd_o,
   output logic                   gnt_valid_o,
   output logic                   grp_release_o
`ifdef COL_ARB_TIMEOUT_EN
   ,
   output logic                   timeout_o
`endif
);

   if (Lvl_COLS < 2 || (1 << Lvl_COL_ADD) < Lvl_COLS || TIMEOUT < 1) begin : g_param_check
      $error("column_rr_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_RELEASE} state_t;

   state_t                 state_q, state_nxt;
   logic [Lvl_COLS-1:0]    mask_q, mask_nxt;
   logic [Lvl_COLS-1:0]    gnt_q, gnt_nxt;
   logic [Lvl_COL_ADD-1:0] yadd_q, yadd_nxt;
   logic [Lvl_COLS-1:0]    masked, pick;
   logic [Lvl_COL_ADD-1:0] pick_idx;
   logic                   complete, done;

`ifdef COL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             timeout_q, timeout_nxt;
   logic             forced;
`endif

   // The x & -x trick isolates the lowest set bit of the masked requests.
   assign masked = req_i & mask_q;
   assign pick   = masked & (~masked + Lvl_COLS'(1));

   always_comb begin
      pick_idx = '0;
      for (int b = 0; b < Lvl_COLS; b++) begin
         if (pick[b]) pick_idx = Lvl_COL_ADD'(b);
      end
   end

   // A request that drops while it is granted counts as an acknowledge.
   assign complete = ack_i | ~(|(req_i & gnt_q));

`ifdef COL_ARB_TIMEOUT_EN
   // Fire on the cycle the counter would reach TIMEOUT, so that the grant is
   // visible for exactly TIMEOUT cycles.
   assign forced = ~complete && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign done   = complete | forced;
`else
   assign done   = complete;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mask_q  <= '1;
         gnt_q   <= '0;
         yadd_q  <= '0;
`ifdef COL_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_nxt;
         mask_q  <= mask_nxt;
         gnt_q   <= gnt_nxt;
         yadd_q  <= yadd_nxt;
`ifdef COL_ARB_TIMEOUT_EN
         cnt_q     <= cnt_nxt;
         timeout_q <= timeout_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state_q;
      mask_nxt  = mask_q;
      gnt_nxt   = gnt_q;
      yadd_nxt  = yadd_q;
`ifdef COL_ARB_TIMEOUT_EN
      cnt_nxt     = '0;
      timeout_nxt = 1'b0;
`endif
      if (!enable_i) begin
         // Dropping the row abandons the pass silently; no release pulse.
         state_nxt = S_IDLE;
         mask_nxt  = '1;
         gnt_nxt   = '0;
         yadd_nxt  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               mask_nxt = '1;
               if (|req_i) state_nxt = S_ARB;
            end
            S_ARB: begin
               if (|masked) begin
                  gnt_nxt   = pick;
                  yadd_nxt  = pick_idx;
                  state_nxt = S_GRANT;
               end else begin
                  state_nxt = S_RELEASE;
               end
            end
            S_GRANT: begin
               if (done) begin
                  // Keep only the columns strictly above the one just served.
                  mask_nxt  = ~(gnt_q | (gnt_q - Lvl_COLS'(1)));
                  gnt_nxt   = '0;
                  yadd_nxt  = '0;
                  state_nxt = S_ARB;
`ifdef COL_ARB_TIMEOUT_EN
                  timeout_nxt = forced;
`endif
               end else begin
`ifdef COL_ARB_TIMEOUT_EN
                  cnt_nxt = cnt_q + CNT_W'(1);
`endif
               end
            end
            S_RELEASE: begin
               mask_nxt  = '1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      gnt_o         = gnt_q;
      yadd_o        = yadd_q;
      gnt_valid_o   = |gnt_q;
      grp_release_o = (state_q == S_RELEASE);
`ifdef COL_ARB_TIMEOUT_EN
      timeout_o     = timeout_q;
`endif
   end

endmodule

// File: tb/tb_column_rr_arbiter.sv
// Testbench for column_rr_arbiter (4 columns). Directed cycle table first,
// then randomized traffic against a pass-level reference model.
module tb_column_rr_arbiter;

   localparam int COLS = 4;
   localparam int ADD  = 2;
   localparam int TMO  = 8;

   logic            clk = 1'b0;
   logic            reset_i = 1'b1;
   logic            enable_i = 1'b0;
   logic [COLS-1:0] req_i = '0;
   logic            ack_i = 1'b0;
   logic [COLS-1:0] gnt_o;
   logic [ADD-1:0]  yadd_o;
   logic            gnt_valid_o;
   logic            grp_release_o;
   logic            timeout_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   column_rr_arbiter #(.Lvl_COLS(COLS), .Lvl_COL_ADD(ADD), .TIMEOUT(TMO)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .enable_i      (enable_i),
      .req_i         (req_i),
      .ack_i         (ack_i),
      .gnt_o         (gnt_o),
      .yadd_o        (yadd_o),
      .gnt_valid_o   (gnt_valid_o),
      .grp_release_o (grp_release_o)
`ifdef COL_ARB_TIMEOUT_EN
      ,
      .timeout_o     (timeout_o)
`endif
   );

`ifndef COL_ARB_TIMEOUT_EN
   assign timeout_o = 1'b0;
`endif

   // Reference model: pass bookkeeping by "last served column" and phase.
   // phase 0 idle, 1 choosing, 2 holding grant, 3 releasing.
   int m_phase = 0;
   int m_last  = -1;
   int m_cur   = -1;
   int m_wait  = 0;
   bit m_to    = 1'b0;

   task automatic model_step(input logic rst, input logic en,
                             input logic [COLS-1:0] req, input logic ack);
      m_to = 1'b0;
      if (rst || !en) begin
         m_phase = 0; m_last = -1; m_cur = -1; m_wait = 0;
      end else begin
         case (m_phase)
            0: begin
               m_last = -1;
               if (req != 0) m_phase = 1;
            end
            1: begin
               int found;
               found = -1;
               for (int j = COLS - 1; j > m_last; j--) if (req[j]) found = j;
               if (found >= 0) begin
                  m_cur = found; m_wait = 0; m_phase = 2;
               end else begin
                  m_phase = 3;
               end
            end
            2: begin
               bit fin;
               fin = ack || !req[m_cur];
`ifdef COL_ARB_TIMEOUT_EN
               if (!fin && (m_wait + 1 >= TMO)) begin
                  fin = 1'b1; m_to = 1'b1;
               end
`endif
               if (fin) begin
                  m_last = m_cur; m_cur = -1; m_phase = 1;
               end else begin
                  m_wait++;
               end
            end
            default: begin
               m_phase = 0; m_last = -1;
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(reset_i, enable_i, req_i, ack_i);
      #1;
   endtask

   task automatic check(input string name, input logic [COLS-1:0] e_gnt,
                        input logic [ADD-1:0] e_yadd, input logic e_valid,
                        input logic e_rel, input logic e_to);
      logic [COLS+ADD+2:0] got, exp;
      got = {gnt_o, yadd_o, gnt_valid_o, grp_release_o, timeout_o};
      exp = {e_gnt, e_yadd, e_valid, e_rel, e_to};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b yadd=%0d valid=%b rel=%b to=%b, expected gnt=%b yadd=%0d valid=%b rel=%b to=%b",
                  name, gnt_o, yadd_o, gnt_valid_o, grp_release_o, timeout_o,
                  e_gnt, e_yadd, e_valid, e_rel, e_to);
      end
   endtask

   typedef struct {
      logic            rst;
      logic            en;
      logic [COLS-1:0] req;
      logic            ack;
      logic [COLS-1:0] gnt;
      logic [ADD-1:0]  yadd;
      logic            valid;
      logic            rel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic en, input logic [COLS-1:0] req,
                      input logic ack, input logic [COLS-1:0] gnt,
                      input logic [ADD-1:0] yadd, input logic valid, input logic rel);
      vec_t v;
      v.rst = rst; v.en = en; v.req = req; v.ack = ack;
      v.gnt = gnt; v.yadd = yadd; v.valid = valid; v.rel = rel;
      tbl.push_back(v);
   endtask

   initial begin
      // reset held two cycles with everything requesting
      add(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
      add(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
      // full pass over 1011
      add(0, 1, 4'b1011, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b0010, 1, 1, 0);
      add(0, 1, 4'b1011, 0, 4'b0010, 1, 1, 0);
      add(0, 1, 4'b1011, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b1000, 3, 1, 0);
      add(0, 1, 4'b1011, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b0000, 0, 0, 1);
      add(0, 1, 4'b1011, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b0001, 0, 1, 0);
      // enable drop during grant of column 1, then restart at column 0
      add(0, 1, 4'b1011, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1011, 0, 4'b0010, 1, 1, 0);
      add(0, 0, 4'b1011, 0, 4'b0000, 0, 0, 0);
      add(0, 0, 4'b0011, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0011, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0011, 0, 4'b0001, 0, 1, 0);
      // withdrawal acts as acknowledge
      add(0, 1, 4'b0100, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 1, 4'b1000, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b1000, 0, 4'b1000, 3, 1, 0);
      add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1);
      add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      // low request rising mid-pass waits for the next pass
      add(0, 1, 4'b0100, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 1, 4'b0101, 0, 4'b0100, 2, 1, 0);
      add(0, 1, 4'b0101, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0101, 0, 4'b0000, 0, 0, 1);
      add(0, 1, 4'b0101, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0101, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0101, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 4'b0101, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0101, 0, 4'b0100, 2, 1, 0);
      // reset wins over an active grant; ack ignored outside GRANT
      add(1, 1, 4'b0101, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0010, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0010, 1, 4'b0010, 1, 1, 0);
      add(0, 1, 4'b0010, 1, 4'b0000, 0, 0, 0);
      add(0, 1, 4'b0010, 0, 4'b0000, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         reset_i  = tbl[i].rst;
         enable_i = tbl[i].en;
         req_i    = tbl[i].req;
         ack_i    = tbl[i].ack;
         tick();
         check($sformatf("vec[%0d]", i), tbl[i].gnt, tbl[i].yadd,
               tbl[i].valid, tbl[i].rel, 1'b0);
      end

      // randomized traffic against the reference model
      reset_i = 1'b1; enable_i = 1'b1; req_i = '0; ack_i = 1'b0;
      tick();
      for (int c = 0; c < 3000; c++) begin
         logic [COLS-1:0] e_gnt;
         logic [ADD-1:0]  e_yadd;
         logic [COLS-1:0] one;
         one = 1;
         e_gnt  = (m_phase == 2) ? (one << m_cur) : '0;
         e_yadd = (m_phase == 2) ? ADD'(m_cur) : '0;
         check($sformatf("rand[%0d]", c), e_gnt, e_yadd, (m_phase == 2),
               (m_phase == 3), m_to);
         reset_i  = ($urandom_range(0, 99) < 1);
         enable_i = ($urandom_range(0, 99) >= 5);
         if ($urandom_range(0, 3) == 0) req_i = COLS'($urandom);
         ack_i    = ($urandom_range(0, 99) < 35);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/column_rr_arbiter.md
Name: column_rr_arbiter

Overview:
Parametrised successor to the row-level column arbiter. It grants active column requests of the selected row one at a time in ascending index order, one pass per row, and holds each grant until the requester acknowledges it. When no unserved requests remain in the pass, it pulses group release so the parent row arbiter can advance. It sits below the row arbiter in the hierarchical event arbitration tree.

Parameters:
- Lvl_COLS, 4, number of columns arbitrated; must be >= 2.
- Lvl_COL_ADD, 2, width of the encoded column address; must be >= clog2(Lvl_COLS).
- TIMEOUT, 8, maximum GRANT-state cycles without acknowledge. Used only with COL_ARB_TIMEOUT_EN; must be >= 1.

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  row selected; arbitration runs only while high.
- req_i  input  Lvl_COLS  per-column request, level sensitive.
- ack_i  input  1  requester acknowledge of the current grant.
- gnt_o  output  Lvl_COLS  one-hot registered grant.
- yadd_o  output  Lvl_COL_ADD  binary index of the granted column; 0 when gnt_o is 0.
- gnt_valid_o  output  1  high exactly when gnt_o is nonzero.
- grp_release_o  output  1  one-cycle pulse at the end of a pass.
- timeout_o  output  1  one-cycle pulse on grant timeout. Present only with COL_ARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, reset_i=1 at an edge):
  - state goes to IDLE; mask goes to all ones.
  - gnt_o=0, yadd_o=0, gnt_valid_o=0, grp_release_o=0, timeout_o=0.
  - Reset has priority over every other input.
- State IDLE:
  - mask is all ones; outputs are zero.
  - If enable_i=1 and req_i is nonzero, go to ARB.
- State ARB:
  - masked = req_i & mask.
  - If masked is nonzero, pick the lowest set bit i. Register gnt_o = one-hot(i), yadd_o = i, gnt_valid_o = 1, and go to GRANT.
  - If masked is zero, go to RELEASE.
- State GRANT:
  - gnt_o and yadd_o are held stable.
  - Completion occurs when ack_i=1, or when req_i[i] falls (withdrawal counts as acknowledge).
  - On completion: mask = all ones shifted left by (i+1), i.e. bits above i only. Clear gnt_o, yadd_o and gnt_valid_o, then go to ARB.
  - Latency: completion sampled at edge N gives gnt_o=0 after N; the next grant appears after edge N+1. There is always one dead cycle between grants.
  - If i = Lvl_COLS-1, the new mask is 0, so the next ARB goes to RELEASE.
- State RELEASE:
  - grp_release_o=1 for exactly one cycle; mask is reset to all ones; go to IDLE.
  - A new pass can begin on the cycle after IDLE.
- Pass semantics:
  - Each column is granted at most once per pass, in ascending order.
  - A request that rises on a column at or below the last granted index waits for the next pass.
  - A request that rises above the last granted index is served in the current pass.
- Ignored inputs: ack_i is ignored outside GRANT. A request that falls in ARB is simply not selected.
- enable_i falling in any state: the next edge clears all outputs, resets the mask and goes to IDLE. No grp_release_o pulse is generated. When re-enabled, the pass restarts at column 0.
- grp_release_o and gnt_valid_o are never high in the same cycle.
- Encoding: yadd_o is zero-extended from i. No arithmetic wrap is needed because i < Lvl_COLS <= 2^Lvl_COL_ADD.

Optional Feature:
- Macro: COL_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) starts at 0 on GRANT entry and increments each GRANT cycle without completion.
  - When it reaches TIMEOUT, the arbiter forces completion: same mask update and dead cycle as a normal completion, and timeout_o pulses in the cycle gnt_o drops.
  - A real ack_i in the same cycle wins, and timeout_o stays 0.
  - The counter clears on reset, on enable_i low and on GRANT exit.
- Undefined: no counter and no timeout_o port. GRANT waits indefinitely for completion.

Test Plan:
All scenarios use Lvl_COLS=4, Lvl_COL_ADD=2.
1. Reset: assert reset_i for 2 cycles with req_i=4'b1111 and enable_i=1 -> gnt_o=0, yadd_o=0, gnt_valid_o=0, grp_release_o=0 while reset is high. First grant 4'b0001 appears 2 cycles after reset falls.
2. Full pass: req_i=4'b1011 held, ack_i pulsed one cycle after each grant -> grants 0001/yadd 0, 0010/yadd 1, 1000/yadd 3, each separated by one zero cycle. Then grp_release_o=1 for one cycle, then a new pass starting at 0001.
3. Late low request: req_i=4'b0100 granted; during GRANT raise req_i[0] -> after ack, no grant to column 0 in this pass. Then grp_release_o pulses, and the next pass grants 0001.
4. Enable drop: during GRANT of 0010, drop enable_i -> next cycle gnt_o=0 with no grp_release_o pulse. Re-enable with req_i=4'b0011 -> grants 0001 first.
5. Withdrawal as ack: grant 0100 held, ack_i=0, req_i[2] falls -> gnt_o=0 next cycle, then grant of the next higher request or grp_release_o.
6. COL_ARB_TIMEOUT_EN, TIMEOUT=3: req_i=4'b0001, never ack -> gnt_o drops after 3 GRANT cycles with timeout_o=1 for one cycle, then grp_release_o pulses.
